// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel request bus between the raster generator and a pixel source
// The generator (master) issues coordinates and request strobes; the pixel
// source (slave) returns 12-bit colour PIX_LAT cycles after each coordinate.
interface vga_timing_gen_if #(
   parameter int CNT_W = 11
);
   logic [CNT_W-1:0] pix_x;
   logic [CNT_W-1:0] pix_y;
   logic             pix_req;
   logic             frame_start;
   logic [11:0]      rgb_in;

   modport master (
      output pix_x,
      output pix_y,
      output pix_req,
      output frame_start,
      input  rgb_in
   );

   modport slave (
      input  pix_x,
      input  pix_y,
      input  pix_req,
      input  frame_start,
      output rgb_in
   );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator and pixel output stage
// Optional feature macro: TEST_PATTERN_EN (adds test_mode input and 8 vertical colour bars).
// Counters run at the pixel clock; de, syncs and colour leave through a
// PIX_LAT+1 deep pipeline so they stay aligned with the returned pixel colour.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int PIX_LAT  = 1,
   parameter int CNT_W    = 11
) (
   input  logic             clk25,
   input  logic             rst_n,
   input  logic             run,
`ifdef TEST_PATTERN_EN
   input  logic             test_mode,
`endif
   vga_timing_gen_if.master pix,
   output logic [3:0]       red_out,
   output logic [3:0]       green_out,
   output logic [3:0]       blue_out,
   output logic             hSync,
   output logic             vSync,
   output logic             de
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   // Active sync levels; the idle level is the complement.
   localparam logic HS_ACT = (HS_POL != 0);
   localparam logic VS_ACT = (VS_POL != 0);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;

   logic h_vis;
   logic v_vis;
   logic de_raw;
   logic hs_raw;
   logic vs_raw;

   // Stage k of each delay line holds the stage-0 value from k cycles ago.
   logic de_pipe [1:PIX_LAT];
   logic hs_pipe [1:PIX_LAT];
   logic vs_pipe [1:PIX_LAT];
`ifdef TEST_PATTERN_EN
   logic [CNT_W-1:0] x_pipe [1:PIX_LAT];
`endif

   logic [11:0] stage_rgb;

`ifdef TEST_PATTERN_EN
   // Eight equal-width vertical bars across the visible line.
   function automatic logic [11:0] bar_colour(input logic [CNT_W-1:0] x);
      int idx;
      idx = (int'(x) * 8) / H_ACTIVE;
      case (idx)
         0:       bar_colour = 12'hFFF;
         1:       bar_colour = 12'hFF0;
         2:       bar_colour = 12'h0FF;
         3:       bar_colour = 12'h0F0;
         4:       bar_colour = 12'hF0F;
         5:       bar_colour = 12'hF00;
         6:       bar_colour = 12'h00F;
         default: bar_colour = 12'h000;
      endcase
   endfunction
`endif

   // Raster counters: h wraps every line, v advances on the h wrap; both freeze when run=0.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (run) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + 1'b1;
            end
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   assign h_vis  = (h_cnt < H_VIS);
   assign v_vis  = (v_cnt < V_VIS);
   // A frozen raster never requests pixels, so the pipeline drains to black.
   assign de_raw = run & h_vis & v_vis;
   // Syncs follow the held counters during run=0, so they keep their last level.
   assign hs_raw = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_ACT : ~HS_ACT;
   assign vs_raw = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_ACT : ~VS_ACT;

   assign pix.pix_x       = h_cnt;
   assign pix.pix_y       = v_cnt;
   // Gated by rst_n so both strobes drop immediately when reset asserts.
   assign pix.pix_req     = rst_n & de_raw;
   assign pix.frame_start = rst_n & run & (h_cnt == '0) & (v_cnt == '0);

   // Delay de/sync (and x for the bar pattern) by PIX_LAT to meet the returned colour.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i <= PIX_LAT; i++) begin
            de_pipe[i] <= 1'b0;
            hs_pipe[i] <= ~HS_ACT;
            vs_pipe[i] <= ~VS_ACT;
`ifdef TEST_PATTERN_EN
            x_pipe[i]  <= '0;
`endif
         end
      end else begin
         de_pipe[1] <= de_raw;
         hs_pipe[1] <= hs_raw;
         vs_pipe[1] <= vs_raw;
`ifdef TEST_PATTERN_EN
         x_pipe[1]  <= h_cnt;
`endif
         for (int i = 2; i <= PIX_LAT; i++) begin
            de_pipe[i] <= de_pipe[i-1];
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
`ifdef TEST_PATTERN_EN
            x_pipe[i]  <= x_pipe[i-1];
`endif
         end
      end
   end

   // Colour source at stage PIX_LAT: upstream pixel or the internal bar pattern.
   always_comb begin
      stage_rgb = pix.rgb_in;
`ifdef TEST_PATTERN_EN
      if (test_mode) begin
         stage_rgb = bar_colour(x_pipe[PIX_LAT]);
      end
`endif
   end

   // Final pin register: colour is forced to black whenever de is low.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         red_out   <= 4'h0;
         green_out <= 4'h0;
         blue_out  <= 4'h0;
         de        <= 1'b0;
         hSync     <= ~HS_ACT;
         vSync     <= ~VS_ACT;
      end else begin
         de    <= de_pipe[PIX_LAT];
         hSync <= hs_pipe[PIX_LAT];
         vSync <= vs_pipe[PIX_LAT];
         if (de_pipe[PIX_LAT]) begin
            red_out   <= stage_rgb[11:8];
            green_out <= stage_rgb[7:4];
            blue_out  <= stage_rgb[3:0];
         end else begin
            red_out   <= 4'h0;
            green_out <= 4'h0;
            blue_out  <= 4'h0;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

   // Small raster for the main instance: 25 x 15 clocks, 375 clocks per frame.
   localparam int HA = 16, HF = 2, HS = 4, HB = 3;
   localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   int total = 0;
   int bad   = 0;

   logic clk25 = 1'b0;
   always #20 clk25 = ~clk25;

   logic       rst_n;
   logic       run;
   logic [3:0] r, g, b;
   logic       hs, vs, de;
`ifdef TEST_PATTERN_EN
   logic       test_mode;
`endif

   logic       rst_def_n;
   logic       run_def;
   logic [3:0] r_d, g_d, b_d;
   logic       hs_d, vs_d, de_d;
   logic       def_done = 1'b0;

   vga_timing_gen_if #(.CNT_W(11)) bus ();
   vga_timing_gen_if #(.CNT_W(11)) bus_def ();

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(0), .VS_POL(0), .PIX_LAT(1), .CNT_W(11)
   ) u_dut (
      .clk25     (clk25),
      .rst_n     (rst_n),
      .run       (run),
`ifdef TEST_PATTERN_EN
      .test_mode (test_mode),
`endif
      .pix       (bus),
      .red_out   (r),
      .green_out (g),
      .blue_out  (b),
      .hSync     (hs),
      .vSync     (vs),
      .de        (de)
   );

   vga_timing_gen u_def (
      .clk25     (clk25),
      .rst_n     (rst_def_n),
      .run       (run_def),
`ifdef TEST_PATTERN_EN
      .test_mode (1'b0),
`endif
      .pix       (bus_def),
      .red_out   (r_d),
      .green_out (g_d),
      .blue_out  (b_d),
      .hSync     (hs_d),
      .vSync     (vs_d),
      .de        (de_d)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic act(input int x, input int y);
      return (x < HA) && (y < VA);
   endfunction

   function automatic logic hs_low(input int x);
      return (x >= HA + HF) && (x < HA + HF + HS);
   endfunction

   function automatic logic vs_low(input int y);
      return (y >= VA + VF) && (y < VA + VF + VS);
   endfunction

   // mode 0: x nibble replicated, mode 1: constant white, mode 2: colour bars (16 px / 8 = 2 px per bar)
   function automatic logic [11:0] pat_col(input int mode, input int x);
      logic [3:0] n;
      n = x[3:0];
      if (mode == 0) return {n, n, n};
      if (mode == 1) return 12'hFFF;
      case (x / 2)
         0:       return 12'hFFF;
         1:       return 12'hFF0;
         2:       return 12'h0FF;
         3:       return 12'h0F0;
         4:       return 12'hF0F;
         5:       return 12'hF00;
         6:       return 12'h00F;
         default: return 12'h000;
      endcase
   endfunction

   int f_err, f_hs, f_vs, f_de, f_fs, f_fs2;
   logic f_de1, f_de2;
   logic [11:0] f_c2, f_c3;

   task automatic do_reset();
      @(negedge clk25);
      rst_n = 1'b0;
      run   = 1'b1;
      repeat (2) @(negedge clk25);
      rst_n = 1'b1;
   endtask

   // Walks one frame plus the pipeline tail from (0,0), comparing every cycle to a bench raster model.
   task automatic run_frame(input int mode);
      int ex, ey, x1, y1, x2, y2;
      logic v1, v2, ede, ehs, evs;
      logic [11:0] ec, col;
      ex = 0; ey = 0; x1 = 0; y1 = 0; x2 = 0; y2 = 0; v1 = 0; v2 = 0;
      f_err = 0; f_hs = 0; f_vs = 0; f_de = 0; f_fs = 0; f_fs2 = 0;
      f_de1 = 0; f_de2 = 0; f_c2 = 0; f_c3 = 0;
      for (int c = 0; c < HT * VT + 2; c++) begin
         #1;
         col = {r, g, b};
         if (bus.pix_x !== 11'(ex) || bus.pix_y !== 11'(ey)) f_err++;
         if (bus.pix_req !== act(ex, ey)) f_err++;
         if (bus.frame_start !== (ex == 0 && ey == 0)) f_err++;
         if (c < HT * VT && bus.frame_start) f_fs++;
         if (c > 0 && bus.frame_start && f_fs2 == 0) f_fs2 = c;
         ede = v2 && act(x2, y2);
         ehs = !(v2 && hs_low(x2));
         evs = !(v2 && vs_low(y2));
         ec  = ede ? pat_col(mode, x2) : 12'h000;
         if (de !== ede || hs !== ehs || vs !== evs || col !== ec) f_err++;
         if (c >= 2) begin
            if (!hs) f_hs++;
            if (!vs) f_vs++;
            if (de)  f_de++;
         end
         if (c == 1) f_de1 = de;
         if (c == 2) begin f_de2 = de; f_c2 = col; end
         if (c == 3) f_c3 = col;
         if (mode == 1)      bus.rgb_in = 12'hFFF;
         else if (mode == 2) bus.rgb_in = 12'h5A5;
         else                bus.rgb_in = v1 ? pat_col(0, x1) : 12'h000;
         v2 = v1; x2 = x1; y2 = y1;
         v1 = 1'b1; x1 = ex; y1 = ey;
         ex++;
         if (ex == HT) begin
            ex = 0;
            ey++;
            if (ey == VT) ey = 0;
         end
         @(negedge clk25);
      end
   endtask

   // Default 800x525 instance: one line of hSync/de widths and blanking.
   initial begin
      int hs_cnt, de_cnt, first, blank_err;
      hs_cnt = 0; de_cnt = 0; first = -1; blank_err = 0;
      rst_def_n = 1'b0;
      run_def   = 1'b1;
      bus_def.rgb_in = 12'hFFF;
      repeat (3) @(negedge clk25);
      rst_def_n = 1'b1;
      for (int i = 0; i < 802; i++) begin
         #1;
         if (i == 0) check("def_frame_start", bus_def.frame_start, 1);
         if (!hs_d) begin
            hs_cnt++;
            if (first < 0) first = i;
         end
         if (de_d) de_cnt++;
         if (!de_d && {r_d, g_d, b_d} != 12'h000) blank_err++;
         @(negedge clk25);
      end
      check("def_hsync_width", hs_cnt, 96);
      check("def_hsync_first", first, 658);
      check("def_de_width", de_cnt, 640);
      check("def_blanking", blank_err, 0);
      def_done = 1'b1;
   end

   initial begin
      logic found;
      int err;
      rst_n = 1'b0;
      run   = 1'b1;
      bus.rgb_in = 12'hFFF;
`ifdef TEST_PATTERN_EN
      test_mode = 1'b0;
`endif
      repeat (3) @(negedge clk25);
      #1;
      check("rst_pix_x", bus.pix_x, 0);
      check("rst_pix_y", bus.pix_y, 0);
      check("rst_pix_req", bus.pix_req, 0);
      check("rst_frame_start", bus.frame_start, 0);
      check("rst_de", de, 0);
      check("rst_rgb", {r, g, b}, 0);
      check("rst_hsync", hs, 1);
      check("rst_vsync", vs, 1);

      // Ramp pattern: alignment and per-frame sync/de widths.
      do_reset();
      run_frame(0);
      check("f0_model", f_err, 0);
      check("f0_hsync_low", f_hs, 60);
      check("f0_vsync_low", f_vs, 50);
      check("f0_de_high", f_de, 128);
      check("f0_frame_starts", f_fs, 1);
      check("f0_frame_period", f_fs2, 375);
      check("f0_de_before", f_de1, 0);
      check("f0_de_rise", f_de2, 1);
      check("f0_first_rgb", f_c2, 12'h000);
      check("f0_second_rgb", f_c3, 12'h111);

      // Constant white: colour must blank outside the visible area.
      do_reset();
      run_frame(1);
      check("f1_blanking", f_err, 0);
      check("f1_de_high", f_de, 128);

`ifdef TEST_PATTERN_EN
      test_mode = 1'b1;
      do_reset();
      run_frame(2);
      check("f2_bars", f_err, 0);
      test_mode = 1'b0;
`endif

      // Pause at (10,3).
      do_reset();
      bus.rgb_in = 12'hFFF;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         #1;
         if (bus.pix_x == 11'd10 && bus.pix_y == 11'd3) found = 1'b1;
         else @(negedge clk25);
      end
      check("pause_reach", found, 1);
      run = 1'b0;
      #1;
      check("pause_req", bus.pix_req, 0);
      @(negedge clk25); #1;
      check("pause_x1", bus.pix_x, 10);
      check("pause_de1", de, 1);
      check("pause_rgb1", {r, g, b}, 12'hFFF);
      @(negedge clk25); #1;
      check("pause_de2", de, 0);
      check("pause_rgb2", {r, g, b}, 12'h000);
      err = 0;
      repeat (48) begin
         @(negedge clk25); #1;
         if (bus.pix_x != 11'd10 || bus.pix_y != 11'd3 || hs !== 1'b1 || vs !== 1'b1 ||
             {r, g, b} != 12'h000 || de !== 1'b0 || bus.pix_req !== 1'b0) err++;
      end
      check("pause_hold", err, 0);
      run = 1'b1;
      #1;
      check("resume_x", bus.pix_x, 10);
      @(negedge clk25); #1;
      check("resume_next_x", bus.pix_x, 11);
      check("resume_next_y", bus.pix_y, 3);

      // Asynchronous reset in the middle of both sync pulses at (20,10).
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         #1;
         if (bus.pix_x == 11'd20 && bus.pix_y == 11'd10) found = 1'b1;
         else @(negedge clk25);
      end
      check("mid_reach", found, 1);
      check("mid_pre_hsync", hs, 0);
      check("mid_pre_vsync", vs, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_x", bus.pix_x, 0);
      check("mid_rst_y", bus.pix_y, 0);
      check("mid_rst_hsync", hs, 1);
      check("mid_rst_vsync", vs, 1);
      check("mid_rst_fs", bus.frame_start, 0);
      check("mid_rst_req", bus.pix_req, 0);
      @(negedge clk25);
      rst_n = 1'b1;
      #1;
      check("mid_rel_fs", bus.frame_start, 1);
      check("mid_rel_x", bus.pix_x, 0);
      check("mid_rel_y", bus.pix_y, 0);
      @(negedge clk25); #1;
      check("mid_next_x", bus.pix_x, 1);
      check("mid_next_fs", bus.frame_start, 0);

      for (int i = 0; i < 2000 && !def_done; i++) @(negedge clk25);
      check("def_done", def_done, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
